// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: access sizes, FSM states and lane helpers.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_NONE = 2'b00,
        SZ_BYTE = 2'b01,
        SZ_HALF = 2'b10,
        SZ_WORD = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_e;

    function automatic logic [3:0] lane_enable(size_e sz, logic [1:0] off);
        logic [3:0] be;
        be = '0;
        case (sz)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = '1;
            default: be = '0;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_data(size_e sz, logic [31:0] d);
        logic [31:0] w;
        w = '0;
        case (sz)
            SZ_BYTE: w = {4{d[7:0]}};
            SZ_HALF: w = {2{d[15:0]}};
            SZ_WORD: w = d;
            default: w = '0;
        endcase
        return w;
    endfunction

    function automatic logic misaligned(size_e sz, logic [1:0] off);
        return ((sz == SZ_HALF) && off[0]) || ((sz == SZ_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory port: word-addressed, byte-enabled request with a ready handshake.
interface mem_access_if;
    logic        dm_req;
    logic        dm_we;
    logic [29:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ready;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        input  dm_ready, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        output dm_ready, dm_rdata
    );
endinterface

// File: rtl/mem_access_load_align.sv
// load_align: selects the addressed lane of a read word and sign-extends byte/half loads.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  size_e       size,
    output logic [31:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[8*offset +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        data     = '0;
        case (size)
            SZ_BYTE: data = {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: data = {{16{half_sel[15]}}, half_sel};
            SZ_WORD: data = rdata;
            default: data = '0;
        endcase
    end
endmodule

// File: rtl/mem_access.sv
// Memory stage: issues sized loads/stores on the data-memory port and registers MEM/WB results.
// Optional macro MEM_ALIGN_CHECK_EN: misaligned half/word accesses complete at once, flagged, without a bus transaction.
module mem_access
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [1:0]  MemWrite_in,
    input  logic [1:0]  MemRead_in,
    input  logic        MemtoReg_in,
    input  logic        RegWrite_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] Aluout_in,
    input  logic [31:0] busB_in,
    output logic        mem_stall,
    mem_access_if.master dm,
    output logic        valid_out,
    output logic        MemtoReg_out,
    output logic        RegWrite_out,
    output logic [4:0]  rd_out,
    output logic [31:0] Aluout_out,
    output logic [31:0] mem_data_out,
    output logic        misalign_out
);
    state_e      state_q, state_d;
    logic        is_store, is_mem, misalign_req, start;
    size_e       req_size;

    logic [31:0] addr_q;
    size_e       size_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        mtr_q, rw_q;
    logic [4:0]  rd_q;
    logic [31:0] load_data;

    // A store takes priority when both size fields are nonzero.
    assign is_store = (MemWrite_in != 2'b00);
    assign is_mem   = is_store || (MemRead_in != 2'b00);
    assign req_size = is_store ? size_e'(MemWrite_in) : size_e'(MemRead_in);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_req = misaligned(req_size, Aluout_in[1:0]);
`else
    assign misalign_req = 1'b0;
`endif

    assign start = valid_in && is_mem && !misalign_req;

    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        mem_stall = 1'b0;
        dm.dm_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_ACCESS;
                    mem_stall = 1'b1;
                end
            end
            ST_ACCESS: begin
                dm.dm_req = 1'b1;
                mem_stall = !dm.dm_ready;
                if (dm.dm_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!reset) mem_stall = 1'b0;
    end

    assign dm.dm_we    = dm.dm_req & we_q;
    assign dm.dm_be    = dm.dm_req ? be_q : '0;
    assign dm.dm_addr  = addr_q[31:2];
    assign dm.dm_wdata = wdata_q;

    load_align u_load_align (
        .rdata  (dm.dm_rdata),
        .offset (addr_q[1:0]),
        .size   (size_q),
        .data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q       <= '0;
            size_q       <= SZ_NONE;
            we_q         <= 1'b0;
            be_q         <= '0;
            wdata_q      <= '0;
            mtr_q        <= 1'b0;
            rw_q         <= 1'b0;
            rd_q         <= '0;
            valid_out    <= 1'b0;
            MemtoReg_out <= 1'b0;
            RegWrite_out <= 1'b0;
            rd_out       <= '0;
            Aluout_out   <= '0;
            mem_data_out <= '0;
            misalign_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (valid_in && !start) begin
                        // Non-memory op, or misaligned access rejected without a transaction.
                        valid_out    <= 1'b1;
                        MemtoReg_out <= MemtoReg_in;
                        RegWrite_out <= RegWrite_in && !misalign_req;
                        rd_out       <= rd_in;
                        Aluout_out   <= Aluout_in;
                        mem_data_out <= '0;
                        misalign_out <= misalign_req;
                    end else if (start) begin
                        addr_q  <= Aluout_in;
                        size_q  <= req_size;
                        we_q    <= is_store;
                        be_q    <= lane_enable(req_size, Aluout_in[1:0]);
                        wdata_q <= lane_data(req_size, busB_in);
                        mtr_q   <= MemtoReg_in;
                        rw_q    <= RegWrite_in;
                        rd_q    <= rd_in;
                    end
                end
                ST_ACCESS: begin
                    if (dm.dm_ready) begin
                        valid_out    <= 1'b1;
                        MemtoReg_out <= mtr_q;
                        RegWrite_out <= rw_q;
                        rd_out       <= rd_q;
                        Aluout_out   <= addr_q;
                        mem_data_out <= we_q ? '0 : load_data;
                        misalign_out <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized ops against a byte-lane model.
module tb_mem_access;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_in = 1'b0;
    logic [1:0]  MemWrite_in = '0, MemRead_in = '0;
    logic        MemtoReg_in = 1'b0, RegWrite_in = 1'b0;
    logic [4:0]  rd_in = '0;
    logic [31:0] Aluout_in = '0, busB_in = '0;
    logic        mem_stall, valid_out, MemtoReg_out, RegWrite_out, misalign_out;
    logic [4:0]  rd_out;
    logic [31:0] Aluout_out, mem_data_out;

    int checks = 0;
    int failures = 0;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    mem_access_if dmif ();

    always #5 clk = ~clk;

    mem_access dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .MemWrite_in  (MemWrite_in),
        .MemRead_in   (MemRead_in),
        .MemtoReg_in  (MemtoReg_in),
        .RegWrite_in  (RegWrite_in),
        .rd_in        (rd_in),
        .Aluout_in    (Aluout_in),
        .busB_in      (busB_in),
        .mem_stall    (mem_stall),
        .dm           (dmif.master),
        .valid_out    (valid_out),
        .MemtoReg_out (MemtoReg_out),
        .RegWrite_out (RegWrite_out),
        .rd_out       (rd_out),
        .Aluout_out   (Aluout_out),
        .mem_data_out (mem_data_out),
        .misalign_out (misalign_out)
    );

    initial begin
        dmif.dm_ready = 1'b0;
        dmif.dm_rdata = '0;
    end

    // Reference model: accesses are n bytes wide at the n-aligned offset within the word.
    function automatic int nbytes(logic [1:0] s);
        return (s == 2'd1) ? 1 : (s == 2'd2) ? 2 : (s == 2'd3) ? 4 : 0;
    endfunction

    function automatic int aligned_off(int n, logic [31:0] a);
        int off;
        off = int'(a[1:0]);
        return off - (off % n);
    endfunction

    function automatic logic [3:0] exp_be(int n, logic [31:0] a);
        logic [3:0] m;
        m = 4'((1 << n) - 1);
        return m << aligned_off(n, a);
    endfunction

    function automatic logic [31:0] exp_wdata(int n, logic [31:0] d);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] exp_load(int n, logic [31:0] a, logic [31:0] r);
        logic [31:0] v;
        v = r >> (8 * aligned_off(n, a));
        if (n == 1) return {{24{v[7]}}, v[7:0]};
        if (n == 2) return {{16{v[15]}}, v[15:0]};
        return r;
    endfunction

    function automatic bit exp_mis(int n, logic [31:0] a);
        return CHK && (((n == 2) && a[0]) || ((n == 4) && (a[1:0] != 2'b00)));
    endfunction

    // Entered and left at 1 time unit after a rising edge with the DUT idle.
    task automatic do_op(input logic [1:0] mw, input logic [1:0] mr, input logic mtr, input logic rw,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] busb,
                         input logic [31:0] rdata, input int wait_cycles, input string name);
        bit is_store;
        int n;
        int stalls;
        valid_in = 1'b1; MemWrite_in = mw; MemRead_in = mr; MemtoReg_in = mtr;
        RegWrite_in = rw; rd_in = rd; Aluout_in = alu; busB_in = busb;
        dmif.dm_ready = 1'b0;
        is_store = (mw != 2'b00);
        n = nbytes(is_store ? mw : mr);
        if (n == 0) begin
            dmif.dm_ready = 1'($urandom_range(0, 1));
            #1;
            checks++; if (mem_stall !== 1'b0) begin failures++; $display("FAIL %s alu_stall got=%0b exp=0", name, mem_stall); end
            checks++; if (dmif.dm_req !== 1'b0) begin failures++; $display("FAIL %s alu_req got=%0b exp=0", name, dmif.dm_req); end
            @(posedge clk); #1;
            checks++; if (valid_out !== 1'b1 || rd_out !== rd || Aluout_out !== alu || RegWrite_out !== rw ||
                          MemtoReg_out !== mtr || mem_data_out !== 32'd0 || misalign_out !== 1'b0) begin
                failures++;
                $display("FAIL %s alu_out got=v%0b rd%0d a%h rw%0b m%0b d%h mis%0b exp=v1 rd%0d a%h rw%0b m%0b d0 mis0",
                         name, valid_out, rd_out, Aluout_out, RegWrite_out, MemtoReg_out, mem_data_out, misalign_out,
                         rd, alu, rw, mtr);
            end
            dmif.dm_ready = 1'b0;
            valid_in = 1'b0;
            return;
        end
        if (exp_mis(n, alu)) begin
            #1;
            checks++; if (mem_stall !== 1'b0 || dmif.dm_req !== 1'b0) begin failures++; $display("FAIL %s mis_issue got=stall%0b req%0b exp=0 0", name, mem_stall, dmif.dm_req); end
            @(posedge clk); #1;
            checks++; if (valid_out !== 1'b1 || misalign_out !== 1'b1 || RegWrite_out !== 1'b0 || dmif.dm_req !== 1'b0 ||
                          rd_out !== rd || Aluout_out !== alu) begin
                failures++;
                $display("FAIL %s mis_out got=v%0b mis%0b rw%0b req%0b rd%0d a%h exp=v1 mis1 rw0 req0 rd%0d a%h",
                         name, valid_out, misalign_out, RegWrite_out, dmif.dm_req, rd_out, Aluout_out, rd, alu);
            end
            valid_in = 1'b0;
            return;
        end
        #1;
        checks++; if (mem_stall !== 1'b1 || dmif.dm_req !== 1'b0) begin failures++; $display("FAIL %s capture got=stall%0b req%0b exp=1 0", name, mem_stall, dmif.dm_req); end
        stalls = 1;
        @(posedge clk); #1;
        for (int k = 0; k <= wait_cycles; k++) begin
            dmif.dm_ready = (k == wait_cycles);
            dmif.dm_rdata = (k == wait_cycles) ? rdata : $urandom;
            #1;
            checks++; if (dmif.dm_req !== 1'b1 || dmif.dm_we !== is_store || dmif.dm_addr !== alu[31:2] ||
                          dmif.dm_be !== exp_be(n, alu) || valid_out !== 1'b0) begin
                failures++;
                $display("FAIL %s access got=req%0b we%0b addr%h be%b v%0b exp=req1 we%0b addr%h be%b v0",
                         name, dmif.dm_req, dmif.dm_we, dmif.dm_addr, dmif.dm_be, valid_out,
                         is_store, alu[31:2], exp_be(n, alu));
            end
            if (is_store) begin
                checks++; if (dmif.dm_wdata !== exp_wdata(n, busb)) begin failures++; $display("FAIL %s wdata got=%h exp=%h", name, dmif.dm_wdata, exp_wdata(n, busb)); end
            end
            checks++; if (mem_stall !== (k != wait_cycles)) begin failures++; $display("FAIL %s access_stall got=%0b exp=%0b", name, mem_stall, k != wait_cycles); end
            if (mem_stall === 1'b1) stalls++;
            @(posedge clk); #1;
        end
        dmif.dm_ready = 1'b0;
        checks++; if (valid_out !== 1'b1 || RegWrite_out !== rw || MemtoReg_out !== mtr || rd_out !== rd ||
                      Aluout_out !== alu || misalign_out !== 1'b0 || dmif.dm_req !== 1'b0) begin
            failures++;
            $display("FAIL %s result got=v%0b rw%0b m%0b rd%0d a%h mis%0b req%0b exp=v1 rw%0b m%0b rd%0d a%h mis0 req0",
                     name, valid_out, RegWrite_out, MemtoReg_out, rd_out, Aluout_out, misalign_out, dmif.dm_req,
                     rw, mtr, rd, alu);
        end
        checks++; if (mem_data_out !== (is_store ? 32'd0 : exp_load(n, alu, rdata))) begin
            failures++; $display("FAIL %s mem_data got=%h exp=%h", name, mem_data_out, is_store ? 32'd0 : exp_load(n, alu, rdata));
        end
        checks++; if (stalls != 1 + wait_cycles) begin failures++; $display("FAIL %s stall_cycles got=%0d exp=%0d", name, stalls, 1 + wait_cycles); end
        valid_in = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        valid_in = 1'b1; MemWrite_in = 2'b11; Aluout_in = 32'h100;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (dmif.dm_req !== 1'b0 || dmif.dm_we !== 1'b0 || dmif.dm_be !== 4'b0 || mem_stall !== 1'b0 ||
                      valid_out !== 1'b0 || MemtoReg_out !== 1'b0 || RegWrite_out !== 1'b0 || misalign_out !== 1'b0) begin
            failures++; $display("FAIL reset_ctrl got=req%0b we%0b be%b stall%0b v%0b m%0b rw%0b mis%0b exp=all0",
                                 dmif.dm_req, dmif.dm_we, dmif.dm_be, mem_stall, valid_out, MemtoReg_out, RegWrite_out, misalign_out);
        end
        checks++; if (rd_out !== 5'd0 || Aluout_out !== 32'd0 || mem_data_out !== 32'd0 || dmif.dm_addr !== 30'd0 || dmif.dm_wdata !== 32'd0) begin
            failures++; $display("FAIL reset_data got=rd%0d a%h d%h addr%h wd%h exp=all0", rd_out, Aluout_out, mem_data_out, dmif.dm_addr, dmif.dm_wdata);
        end
        valid_in = 1'b0; MemWrite_in = '0;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_word_store();
        do_op(2'b11, 2'b00, 1'b0, 1'b0, 5'd0, 32'h100, 32'hDEADBEEF, 32'h0, 0, "word_store");
    endtask

    task automatic test_byte_load();
        do_op(2'b00, 2'b01, 1'b1, 1'b1, 5'd7, 32'h103, 32'h0, 32'h80000000, 3, "byte_load");
        checks++; if (mem_data_out !== 32'hFFFFFF80) begin failures++; $display("FAIL byte_load_const got=%h exp=ffffff80", mem_data_out); end
    endtask

    task automatic test_half_store();
        do_op(2'b10, 2'b00, 1'b0, 1'b0, 5'd0, 32'h102, 32'h1234ABCD, 32'h0, 1, "half_store");
    endtask

    task automatic test_alu_op();
        do_op(2'b00, 2'b00, 1'b0, 1'b1, 5'd12, 32'hCAFE0001, 32'h5555AAAA, 32'h0, 0, "alu_op");
    endtask

    task automatic test_store_wins();
        do_op(2'b01, 2'b11, 1'b0, 1'b1, 5'd3, 32'h2001, 32'h000000A5, 32'h0, 0, "store_wins");
    endtask

    task automatic test_reset_mid_access();
        valid_in = 1'b1; MemWrite_in = 2'b00; MemRead_in = 2'b11; Aluout_in = 32'h40; rd_in = 5'd9;
        RegWrite_in = 1'b1; MemtoReg_in = 1'b1; dmif.dm_ready = 1'b0;
        @(posedge clk); #1;
        checks++; if (dmif.dm_req !== 1'b1) begin failures++; $display("FAIL rst_mid_pre got=%0b exp=1", dmif.dm_req); end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (dmif.dm_req !== 1'b0 || valid_out !== 1'b0) begin failures++; $display("FAIL rst_mid_drop got=req%0b v%0b exp=0 0", dmif.dm_req, valid_out); end
        reset = 1'b1; valid_in = 1'b0; dmif.dm_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (dmif.dm_req !== 1'b0 || valid_out !== 1'b0) begin failures++; $display("FAIL rst_mid_idle got=req%0b v%0b exp=0 0", dmif.dm_req, valid_out); end
        dmif.dm_ready = 1'b0;
    endtask

    task automatic test_misalign();
        do_op(2'b00, 2'b11, 1'b1, 1'b1, 5'd4, 32'h101, 32'h0, 32'h89ABCDEF, 0, "word_load_101");
`ifdef MEM_ALIGN_CHECK_EN
        checks++; if (misalign_out !== 1'b1 || RegWrite_out !== 1'b0) begin failures++; $display("FAIL misalign_flag got=mis%0b rw%0b exp=1 0", misalign_out, RegWrite_out); end
`else
        checks++; if (misalign_out !== 1'b0 || mem_data_out !== 32'h89ABCDEF) begin failures++; $display("FAIL misalign_ignored got=mis%0b d%h exp=0 89abcdef", misalign_out, mem_data_out); end
`endif
    endtask

    task automatic test_back_to_back();
        do_op(2'b00, 2'b10, 1'b1, 1'b1, 5'd1, 32'h3002, 32'h0, 32'h7FFF8001, 0, "b2b_a");
        do_op(2'b01, 2'b00, 1'b0, 1'b0, 5'd2, 32'h3001, 32'h12345678, 32'h0, 2, "b2b_b");
        do_op(2'b00, 2'b01, 1'b1, 1'b1, 5'd3, 32'h3002, 32'h0, 32'h00420000, 1, "b2b_c");
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            logic [1:0] mw, mr;
            int sel;
            sel = $urandom_range(0, 3);
            mw = (sel == 1) ? 2'($urandom_range(1, 3)) : 2'b00;
            mr = (sel >= 2) ? 2'($urandom_range(1, 3)) : 2'b00;
            if (sel == 3 && $urandom_range(0, 1) == 1) mw = 2'($urandom_range(1, 3));
            do_op(mw, mr, 1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
                  $urandom_range(0, 3), "random");
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
                checks++; if (valid_out !== 1'b0 || dmif.dm_req !== 1'b0) begin failures++; $display("FAIL random_gap got=v%0b req%0b exp=0 0", valid_out, dmif.dm_req); end
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_word_store();
        test_byte_load();
        test_half_store();
        test_alu_op();
        test_store_wins();
        test_reset_mid_access();
        test_misalign();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-stage access unit of the five-stage pipeline: the consumer of the execute stage's memory controls, ALU address and store data. It converts byte/half/word load and store requests into word-addressed, byte-enabled transactions on a ready-handshaked data-memory port with variable latency. It stalls the upstream pipeline while a transaction is in flight and registers results into the MEM/WB boundary.

## Interface
- No parameters.
- clk  in  1  pipeline clock; all state on rising edge
- reset  in  1  synchronous, active-low reset
- valid_in  in  1  execute-stage output holds a live instruction
- MemWrite_in  in  2  store size: 00 none, 01 byte, 10 half, 11 word
- MemRead_in  in  2  load size, same encoding
- MemtoReg_in  in  1  writeback selects memory data
- RegWrite_in  in  1  instruction writes a register
- rd_in  in  5  destination register
- Aluout_in  in  32  byte address, or ALU result for non-memory ops
- busB_in  in  32  store data
- mem_stall  out  1  hold execute stage and earlier this cycle
- dm_req  out  1  memory transaction valid
- dm_we  out  1  1 = write
- dm_addr  out  30  word address (byte address [31:2])
- dm_be  out  4  byte enables, bit n = byte lane n
- dm_wdata  out  32  lane-replicated store data
- dm_ready  in  1  memory accepts/completes the current transaction this cycle
- dm_rdata  in  32  read word, valid when dm_ready=1 on a read
- valid_out, MemtoReg_out, RegWrite_out  out  1 each  registered MEM/WB controls
- rd_out  out  5  registered destination
- Aluout_out  out  32  registered ALU result
- mem_data_out  out  32  registered, extended load data
- misalign_out  out  1  registered misaligned-access flag

## Operation
- FSM states IDLE and ACCESS; reset value IDLE.
- IDLE, valid_in=1, MemWrite_in=MemRead_in=00: pass-through; MEM/WB registers load inputs at next edge, mem_data_out ← 0.
- IDLE, valid_in=1, memory op: capture address, size, direction, lane-prepared data and controls; go to ACCESS. mem_stall=1 combinationally this cycle.
- If both MemWrite_in and MemRead_in are nonzero, the store wins; other controls pass unchanged.
- ACCESS: dm_req=1 with dm_we/dm_addr/dm_be/dm_wdata driven from captured registers, stable until dm_ready. mem_stall = !dm_ready. When dm_ready=1, MEM/WB registers load (valid_out=1, load data from dm_rdata), go to IDLE.
- valid_in is ignored in ACCESS; upstream holds it because of mem_stall.
- Byte lanes, little-endian. Byte: be = 1<<addr[1:0], wdata = {4{busB[7:0]}}. Half: be = addr[1] ? 1100 : 0011, wdata = {2{busB[15:0]}}. Word: be = 1111, wdata = busB.
- Loads: byte and half are sign-extended from the selected lane; word is unchanged.
- valid_out=0 whenever the stage emits nothing (IDLE with valid_in=0, or ACCESS with dm_ready=0); the other MEM/WB outputs then hold.

## Timing
- Reset: state IDLE; dm_req, dm_we, dm_be, mem_stall, valid_out, MemtoReg_out, RegWrite_out, misalign_out = 0; rd_out, Aluout_out, mem_data_out, dm_addr, dm_wdata = 0.
- Reset asserted mid-ACCESS: dm_req drops at that edge and the transaction is abandoned; no valid_out.
- Non-memory latency: 1 cycle, no stall.
- Memory latency: 2 + W cycles, where W is the number of ACCESS cycles with dm_ready=0. Stall cycles = 1 + W.
- dm_ready while dm_req=0 is ignored.
- Back-to-back memory ops: the second op is captured in the IDLE cycle following completion; there is no bubble beyond that capture cycle.

## Configuration
- MEM_ALIGN_CHECK_EN defined: a half access with addr[0]=1 or a word access with addr[1:0]≠00 does not enter ACCESS and issues no dm_req. It completes in 1 cycle with valid_out=1, misalign_out=1, RegWrite_out=0, and no stall.
- MEM_ALIGN_CHECK_EN undefined: low address bits below the access size are ignored (half uses addr[1] only, word uses neither). misalign_out is tied to 0.

## Structure
- Shared package mem_pkg: size encodings (SZ_NONE/SZ_BYTE/SZ_HALF/SZ_WORD) and the FSM state enum (ST_IDLE, ST_ACCESS).
- One sub-module, load_align: combinational lane select and sign extension from dm_rdata, addr[1:0] and size.

## Test plan
- Word store: Aluout_in=0x100, busB_in=0xDEADBEEF, dm_ready high on the 1st ACCESS cycle -> dm_addr=0x40, be=1111, wdata=0xDEADBEEF; 1 stall cycle; valid_out 2 cycles after capture.
- Byte load: addr 0x103, dm_rdata=0x80000000, dm_ready delayed 3 cycles -> mem_data_out=0xFFFFFF80, 4 stall cycles, be=1000.
- Half store at 0x102, busB_in=0x1234ABCD -> be=1100, wdata=0xABCDABCD.
- ALU op with no memory access, valid_in=1 -> outputs registered next cycle, mem_stall never asserted.
- Reset low during ACCESS -> dm_req=0 and state IDLE after that edge, no valid_out.
- With MEM_ALIGN_CHECK_EN, word load at 0x101 -> no dm_req; misalign_out=1 and RegWrite_out=0 next cycle.
